// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, output register plus one-entry skid.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_valid,
  output logic        o_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StKill, StFull, StErr} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] kill_addr_q;
  logic        first_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] opc_q;
  logic [31:0] opc4_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;

  logic        ack;
  logic        consume;
  logic        redir_bad;
  logic [31:0] redir_pc;
  logic [31:0] pc_plus4;

  // An ack in the first cycle after reset belongs to an abandoned request.
  assign ack      = i_imem_ack & ~first_q;
  assign consume  = valid_q & ~i_stall;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  assign redir_bad = |i_redirect_pc[1:0];
  assign redir_pc  = i_redirect_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misalign_q <= 1'b0;
    end else if (i_redirect) begin
      misalign_q <= redir_bad;
    end
  end

  assign o_misalign = misalign_q;
`else
  assign redir_bad  = 1'b0;
  assign redir_pc   = i_redirect_pc & 32'hFFFF_FFFC;
  assign o_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      first_q      <= 1'b1;
      valid_q      <= 1'b0;
      instr_q      <= NOP;
      opc_q        <= '0;
      opc4_q       <= '0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
    end else begin
      first_q <= 1'b0;
      if (i_redirect) begin
        valid_q      <= 1'b0;
        instr_q      <= NOP;
        skid_instr_q <= NOP;
        skid_pc_q    <= '0;
        pc_q         <= redir_pc;
        if (redir_bad) begin
          state_q <= StErr;
        end else begin
          unique case (state_q)
            StFetch: begin
              // Remember the in-flight address so it stays on the bus until its ack.
              kill_addr_q <= pc_q;
              state_q     <= ack ? StFetch : StKill;
            end
            StKill:  state_q <= ack ? StFetch : StKill;
            default: state_q <= StFetch;
          endcase
        end
      end else begin
        unique case (state_q)
          StFetch: begin
            if (ack) begin
              pc_q <= pc_plus4;
              if (valid_q && i_stall) begin
                skid_instr_q <= i_imem_rdata;
                skid_pc_q    <= pc_q;
                state_q      <= StFull;
              end else begin
                instr_q <= i_imem_rdata;
                opc_q   <= pc_q;
                opc4_q  <= pc_plus4;
                valid_q <= 1'b1;
              end
            end else if (consume) begin
              valid_q <= 1'b0;
            end
          end
          StKill: begin
            if (ack) begin
              state_q <= StFetch;
            end
            if (consume) begin
              valid_q <= 1'b0;
            end
          end
          StFull: begin
            if (consume) begin
              instr_q <= skid_instr_q;
              opc_q   <= skid_pc_q;
              opc4_q  <= skid_pc_q + 32'd4;
              state_q <= StFetch;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_imem_req  = ((state_q == StFetch) || (state_q == StKill)) && !i_rst;
  assign o_imem_addr = (state_q == StKill) ? kill_addr_q : pc_q;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_pc_four   = opc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, directed and random stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst = 1'b1, d_stall = 1'b0, d_redir = 1'b0, d_ack = 1'b0;
  logic [31:0] d_rpc = '0, d_rdata = '0;

  logic        o_imem_req, o_valid, o_misalign;
  logic [31:0] o_imem_addr, o_instr, o_pc, o_pc_four;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst        (d_rst),
    .i_stall      (d_stall),
    .i_redirect   (d_redir),
    .i_redirect_pc(d_rpc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (d_ack),
    .i_imem_rdata (d_rdata),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_pc_four    (o_pc_four),
    .o_valid      (o_valid),
    .o_misalign   (o_misalign)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: fetched-but-unconsumed instructions in a queue of at most two.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = RST_PC, m_stale_addr = '0, m_instr = NOP, m_opc = '0, m_opc4 = '0;
  logic        m_stale = 1'b0, m_ignore = 1'b1, m_err = 1'b0, m_mis = 1'b0;
  logic [31:0] rdata_xor = '0;

  function automatic logic exp_req();
    return !d_rst && !m_err && (m_stale || q.size() < 2);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic        req_now, ack_eff, bad;
    logic [31:0] tgt;
    if (d_rst) begin
      q.delete();
      m_pc = RST_PC; m_stale = 1'b0; m_ignore = 1'b1; m_instr = NOP;
      m_opc = '0; m_opc4 = '0; m_err = 1'b0; m_mis = 1'b0;
    end else begin
      req_now  = !m_err && (m_stale || q.size() < 2);
      ack_eff  = d_ack && req_now && !m_ignore;
      m_ignore = 1'b0;
      if (d_redir) begin
        bad = CHK && (d_rpc[1:0] != 2'b00);
        tgt = CHK ? d_rpc : (d_rpc & 32'hFFFF_FFFC);
        q.delete();
        m_instr = NOP; m_mis = bad; m_err = bad;
        if (!bad && req_now && !ack_eff) begin
          if (!m_stale) m_stale_addr = m_pc;
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
        end
        m_pc = tgt;
      end else begin
        if (q.size() > 0 && !d_stall) void'(q.pop_front());
        if (ack_eff) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            q.push_back('{instr: d_rdata, pc: m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      if (q.size() > 0) begin
        m_instr = q[0].instr; m_opc = q[0].pc; m_opc4 = q[0].pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chkb("req", o_imem_req, exp_req());
    if (exp_req()) chk("addr", o_imem_addr, exp_addr());
    chkb("valid", o_valid, q.size() > 0);
    chk("instr", o_instr, m_instr);
    chk("pc", o_pc, m_opc);
    chk("pc_four", o_pc_four, m_opc4);
    chkb("misalign", o_misalign, m_mis);
  endtask

  // Inputs change at the falling edge; ack is only offered while a request is expected.
  task automatic drive(input int rst, input int stall, input int redir, input logic [31:0] rpc,
                       input int ack, input int junk);
    d_rst   = (rst != 0);
    d_stall = (stall != 0);
    d_redir = (redir != 0);
    d_rpc   = rpc;
    d_ack   = (ack != 0) && exp_req();
    d_rdata = (junk != 0) ? JUNK : (d_ack ? (exp_addr() ^ rdata_xor) : $urandom);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1, 0, 0, '0, 0, 0);
    cycle();
    cycle();
    chkb("rst_valid", o_valid, 1'b0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pc_four", o_pc_four, 32'h0);
    chkb("rst_req", o_imem_req, 1'b0);
    chkb("rst_misalign", o_misalign, 1'b0);

    // First cycle after release: request at RESET_PC, junk ack ignored.
    drive(0, 0, 0, '0, 1, 1);
    chkb("first_req", o_imem_req, 1'b1);
    chk("first_addr", o_imem_addr, 32'h100);
    cycle();
    chkb("ignored_ack_valid", o_valid, 1'b0);

    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("seq0_pc", o_pc, 32'h100);
    chk("seq0_instr", o_instr, 32'h100);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("seq1_pc", o_pc, 32'h104);
    chk("seq1_pc_four", o_pc_four, 32'h108);
    chkb("seq1_valid", o_valid, 1'b1);

    // Stall three cycles while memory keeps acking: 0x108 parks in the skid.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, 1, 0); cycle();
      chk("stall_pc", o_pc, 32'h104);
      chkb("full_req", o_imem_req, 1'b0);
    end
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("rel0_pc", o_pc, 32'h108);
    chk("rel0_instr", o_instr, 32'h108);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("rel1_pc", o_pc, 32'h10C);

    // Redirect with a request outstanding; stale ack arrives two cycles later.
    drive(0, 0, 1, 32'h200, 0, 0); cycle();
    chkb("kill_valid", o_valid, 1'b0);
    chk("kill_instr", o_instr, NOP);
    chk("kill_addr", o_imem_addr, 32'h110);
    drive(0, 0, 0, '0, 0, 0); cycle();
    chk("kill_addr_hold", o_imem_addr, 32'h110);
    drive(0, 0, 0, '0, 1, 1); cycle();
    chkb("stale_valid", o_valid, 1'b0);
    chk("new_addr", o_imem_addr, 32'h200);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("redir_pc", o_pc, 32'h200);
    chk("redir_instr", o_instr, 32'h200);

    // Redirect and ack in the same cycle.
    drive(0, 0, 1, 32'h200, 1, 1); cycle();
    chkb("same_valid", o_valid, 1'b0);
    chk("same_addr", o_imem_addr, 32'h200);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("same_pc", o_pc, 32'h200);
    chk("same_instr", o_instr, 32'h200);

    // Address wrap-around.
    drive(0, 0, 1, 32'hFFFF_FFFC, 1, 1); cycle();
    chk("wrap_req_addr", o_imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_four", o_pc_four, 32'h0);
    chk("wrap_next_addr", o_imem_addr, 32'h0);

    drive(0, 0, 1, 32'h202, 1, 1); cycle();
`ifdef FETCH_MISALIGN_CHK_EN
    chkb("mis_set", o_misalign, 1'b1);
    chkb("mis_req", o_imem_req, 1'b0);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chkb("mis_req_hold", o_imem_req, 1'b0);
    drive(0, 0, 1, 32'h300, 0, 0); cycle();
    chkb("mis_clear", o_misalign, 1'b0);
    chk("mis_resume_addr", o_imem_addr, 32'h300);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("mis_resume_pc", o_pc, 32'h300);
`else
    chkb("mis_tied", o_misalign, 1'b0);
    chk("mis_forced_addr", o_imem_addr, 32'h200);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("mis_forced_pc", o_pc, 32'h200);
`endif

    // Reset with a request outstanding.
    drive(1, 0, 0, '0, 0, 0); cycle();
    chkb("midrst_req", o_imem_req, 1'b0);
    chkb("midrst_valid", o_valid, 1'b0);
    drive(0, 0, 0, '0, 1, 1); cycle();
    chkb("midrst_ign", o_valid, 1'b0);
    drive(0, 0, 0, '0, 1, 0); cycle();
    chk("midrst_pc", o_pc, 32'h100);
    chk("midrst_instr", o_instr, 32'h100);

    rdata_xor = $urandom;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(7, 0) != 0) r = r & 32'hFFFF_FFFC;
      if ($urandom_range(31, 0) == 0) r = 32'hFFFF_FFF8;
      drive(($urandom_range(199, 0) == 0) ? 1 : 0,
            ($urandom_range(9, 0) < 3) ? 1 : 0,
            ($urandom_range(19, 0) == 0) ? 1 : 0,
            r,
            ($urandom_range(9, 0) < 6) ? 1 : 0,
            0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
